// File: rtl/branch_predict_unit.sv
// ID-stage branch resolver with a 2-bit counter BHT for IF prediction and a
// circular return-address stack for JR $31. Resolution is combinational on
// the ID inputs; redirect/flush/link outputs are registered for one cycle.
module branch_predict_unit #(
  parameter int DATA_W    = 32,
  parameter int BHT_DEPTH = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] if_pc,
  output logic              if_pred_taken,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              id_pred_taken,
  input  logic [DATA_W-1:0] id_sign_ext_imm,
  input  logic [DATA_W-1:0] rf_rs_val,
  input  logic [DATA_W-1:0] rf_rt_val,
  input  logic              ex_wr_en,
  input  logic [4:0]        ex_wr_reg,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic              mem_wr_en,
  input  logic [4:0]        mem_wr_reg,
  input  logic [DATA_W-1:0] mem_alu_res,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              flush,
  output logic              link_we,
  output logic [4:0]        link_reg,
  output logic [DATA_W-1:0] link_value,
  output logic              ras_underflow
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] FN_JR      = 6'd8;

  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [4:0]       REG_RA   = 5'd31;

  // ---------------------------------------------------------------- decode
  logic [5:0]  opcode;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [5:0]  funct;
  logic [25:0] jidx;
  logic        is_beq, is_bne, is_j, is_jal, is_jr;

  assign opcode = id_instr[31:26];
  assign rs_idx = id_instr[25:21];
  assign rt_idx = id_instr[20:16];
  assign funct  = id_instr[5:0];
  assign jidx   = id_instr[25:0];

  assign is_beq = (opcode == OP_BEQ);
  assign is_bne = (opcode == OP_BNE);
  assign is_j   = (opcode == OP_J);
  assign is_jal = (opcode == OP_JAL);
  assign is_jr  = (opcode == OP_SPECIAL) && (funct == FN_JR);

  logic unused_instr;
  assign unused_instr = ^id_instr[15:6];

  // ------------------------------------------------------------ forwarding
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  // EX beats MEM beats register file; $0 always reads the register file.
  always_comb begin
    rs_val = rf_rs_val;
    if (ex_wr_en && (ex_wr_reg == rs_idx) && (rs_idx != 5'd0))
      rs_val = ex_alu_res;
    else if (mem_wr_en && (mem_wr_reg == rs_idx) && (rs_idx != 5'd0))
      rs_val = mem_alu_res;
  end

  // Same precedence applied independently to rt.
  always_comb begin
    rt_val = rf_rt_val;
    if (ex_wr_en && (ex_wr_reg == rt_idx) && (rt_idx != 5'd0))
      rt_val = ex_alu_res;
    else if (mem_wr_en && (mem_wr_reg == rt_idx) && (rt_idx != 5'd0))
      rt_val = mem_alu_res;
  end

  // ------------------------------------------------------------------- BHT
  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] id_idx;

  assign if_idx        = if_pc[IDX_W-1:0];
  assign id_idx        = id_pc[IDX_W-1:0];
  // Lookup reads the registered table, so a same-cycle update is not visible.
  assign if_pred_taken = bht[if_idx][1];

  // ------------------------------------------------------------------- RAS
  logic [DATA_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;
  logic [CNT_W-1:0]  ras_cnt;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;
  logic              ras_empty;
  logic [DATA_W-1:0] ras_top;

  // ras_ptr is the next write slot; the newest entry sits one below it.
  assign ptr_inc   = (ras_ptr == PTR_MAX) ? '0 : ras_ptr + 1'b1;
  assign ptr_dec   = (ras_ptr == '0) ? PTR_MAX : ras_ptr - 1'b1;
  assign ras_empty = (ras_cnt == '0);
  assign ras_top   = ras_mem[ptr_dec];

  // ------------------------------------------------------------ resolution
  logic [DATA_W-1:0] br_target;
  logic [DATA_W-1:0] fall_through;
  logic [DATA_W-1:0] ret_addr;
  logic [DATA_W-1:0] j_target;
  logic [31:0]       pc32;
  logic              br_taken;
  logic [DATA_W-1:0] jr_pred;

  assign br_target    = id_pc + id_sign_ext_imm + DATA_W'(1);
  assign fall_through = id_pc + DATA_W'(1);
  assign ret_addr     = id_pc + DATA_W'(2);
  assign pc32         = 32'(id_pc);
  assign j_target     = DATA_W'((pc32 & 32'hF000_0000) | {6'd0, jidx});
  assign br_taken     = is_beq ? (rs_val == rt_val) : (rs_val != rt_val);
  assign jr_pred      = (rs_idx == REG_RA && !ras_empty) ? ras_top : '0;

  logic              nxt_redirect;
  logic [DATA_W-1:0] nxt_redirect_pc;
  logic              nxt_link_we;
  logic [4:0]        nxt_link_reg;
  logic [DATA_W-1:0] nxt_link_value;
  logic              bht_we;
  logic              bht_up;
  logic              ras_push;
  logic              ras_pop;
  logic              set_underflow;

  // Decide next registered outputs and the table/stack side effects.
  always_comb begin
    nxt_redirect    = 1'b0;
    nxt_redirect_pc = '0;
    nxt_link_we     = 1'b0;
    nxt_link_reg    = 5'd0;
    nxt_link_value  = '0;
    bht_we          = 1'b0;
    bht_up          = 1'b0;
    ras_push        = 1'b0;
    ras_pop         = 1'b0;
    set_underflow   = 1'b0;
    if (id_valid) begin
      if (is_beq || is_bne) begin
        bht_we = 1'b1;
        bht_up = br_taken;
        if (br_taken != id_pred_taken) begin
          nxt_redirect    = 1'b1;
          nxt_redirect_pc = br_taken ? br_target : fall_through;
        end
      end else if (is_j || is_jal) begin
        nxt_redirect    = 1'b1;
        nxt_redirect_pc = j_target;
        if (is_jal) begin
          nxt_link_we    = 1'b1;
          nxt_link_reg   = REG_RA;
          nxt_link_value = ret_addr;
          ras_push       = 1'b1;
        end
      end else if (is_jr) begin
        if (rs_idx == REG_RA) begin
          if (ras_empty) set_underflow = 1'b1;
          else           ras_pop       = 1'b1;
        end
        if (jr_pred != rs_val) begin
          nxt_redirect    = 1'b1;
          nxt_redirect_pc = rs_val;
        end
      end
    end
  end

  // Saturating 2-bit counter update; reset leaves every entry weakly not-taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (bht_we) begin
      if (bht_up) begin
        if (bht[id_idx] != 2'b11) bht[id_idx] <= bht[id_idx] + 2'b01;
      end else begin
        if (bht[id_idx] != 2'b00) bht[id_idx] <= bht[id_idx] - 2'b01;
      end
    end
  end

  // Circular return stack: a push when full overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (ras_push) begin
      ras_mem[ras_ptr] <= ret_addr;
      ras_ptr          <= ptr_inc;
      if (ras_cnt != CNT_FULL) ras_cnt <= ras_cnt + 1'b1;
    end else if (ras_pop) begin
      ras_ptr <= ptr_dec;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end

  // Register resolution results; each pulse lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect      <= 1'b0;
      redirect_pc   <= '0;
      flush         <= 1'b0;
      link_we       <= 1'b0;
      link_reg      <= 5'd0;
      link_value    <= '0;
      ras_underflow <= 1'b0;
    end else begin
      redirect    <= nxt_redirect;
      redirect_pc <= nxt_redirect_pc;
      flush       <= nxt_redirect;
      link_we     <= nxt_link_we;
      link_reg    <= nxt_link_reg;
      link_value  <= nxt_link_value;
      if (set_underflow) ras_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: a queue/array reference model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_branch_predict_unit;

  localparam int DW   = 32;
  localparam int BHTD = 16;
  localparam int RASD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] if_pc = '0;
  logic          if_pred_taken;
  logic          id_valid = 1'b0;
  logic [31:0]   id_instr = '0;
  logic [DW-1:0] id_pc = '0;
  logic          id_pred_taken = 1'b0;
  logic [DW-1:0] id_sign_ext_imm = '0;
  logic [DW-1:0] rf_rs_val = '0;
  logic [DW-1:0] rf_rt_val = '0;
  logic          ex_wr_en = 1'b0;
  logic [4:0]    ex_wr_reg = '0;
  logic [DW-1:0] ex_alu_res = '0;
  logic          mem_wr_en = 1'b0;
  logic [4:0]    mem_wr_reg = '0;
  logic [DW-1:0] mem_alu_res = '0;
  logic          redirect, flush, link_we, ras_underflow;
  logic [DW-1:0] redirect_pc, link_value;
  logic [4:0]    link_reg;

  branch_predict_unit #(.DATA_W(DW), .BHT_DEPTH(BHTD), .RAS_DEPTH(RASD)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_pred_taken(id_pred_taken), .id_sign_ext_imm(id_sign_ext_imm),
    .rf_rs_val(rf_rs_val), .rf_rt_val(rf_rt_val),
    .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_alu_res(ex_alu_res),
    .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .mem_alu_res(mem_alu_res),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .link_we(link_we), .link_reg(link_reg), .link_value(link_value),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- reference model
  int          bht_m [BHTD];
  logic [31:0] ras_q [$];
  bit          uf_m = 0;
  bit          exp_rst = 0;
  bit          exp_redirect = 0;
  logic [31:0] exp_pc = '0;
  bit          exp_lwe = 0;
  logic [4:0]  exp_lreg = '0;
  logic [31:0] exp_lval = '0;

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
    if (r != 0 && ex_wr_en && ex_wr_reg == r) return ex_alu_res;
    if (r != 0 && mem_wr_en && mem_wr_reg == r) return mem_alu_res;
    return rf;
  endfunction

  task automatic model_step();
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [31:0] a, b, pred;
    bit          taken;
    int          k;
    exp_rst = 0; exp_redirect = 0; exp_pc = 0;
    exp_lwe = 0; exp_lreg = 0; exp_lval = 0;
    if (reset) begin
      for (int i = 0; i < BHTD; i++) bht_m[i] = 1;
      ras_q.delete();
      uf_m = 0;
      exp_rst = 1;
      return;
    end
    if (!id_valid) return;
    op = id_instr[31:26];
    rs = id_instr[25:21];
    a  = fwd(rs, rf_rs_val);
    b  = fwd(id_instr[20:16], rf_rt_val);
    k  = int'(id_pc % BHTD);
    if (op == 4 || op == 5) begin
      taken = (op == 4) ? (a == b) : (a != b);
      exp_redirect = (taken != id_pred_taken);
      exp_pc = taken ? id_pc + id_sign_ext_imm + 1 : id_pc + 1;
      if (taken) bht_m[k] = (bht_m[k] < 3) ? bht_m[k] + 1 : 3;
      else       bht_m[k] = (bht_m[k] > 0) ? bht_m[k] - 1 : 0;
    end else if (op == 2 || op == 3) begin
      exp_redirect = 1;
      exp_pc = (id_pc & 32'hF000_0000) | {6'd0, id_instr[25:0]};
      if (op == 3) begin
        exp_lwe = 1; exp_lreg = 31; exp_lval = id_pc + 2;
        ras_q.push_back(id_pc + 2);
        if (ras_q.size() > RASD) void'(ras_q.pop_front());
      end
    end else if (op == 0 && id_instr[5:0] == 8) begin
      pred = 0;
      if (rs == 31) begin
        if (ras_q.size() > 0) pred = ras_q.pop_back();
        else uf_m = 1;
      end
      exp_redirect = (pred != a);
      exp_pc = a;
    end
  endtask

  // Single compare process: model advances on the edge, DUT is checked 1ns later.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("redirect", {31'd0, redirect}, {31'd0, exp_redirect});
    chk("flush", {31'd0, flush}, {31'd0, exp_redirect});
    chk("link_we", {31'd0, link_we}, {31'd0, exp_lwe});
    chk("link_reg", {27'd0, link_reg}, {27'd0, exp_lreg});
    chk("ras_underflow", {31'd0, ras_underflow}, {31'd0, uf_m});
    chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, bht_m[if_pc % BHTD] >= 2});
    if (exp_redirect) chk("redirect_pc", redirect_pc, exp_pc);
    if (exp_lwe) chk("link_value", link_value, exp_lval);
    if (exp_rst) begin
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_link_value", link_value, 0);
    end
  end

  // ---------------------------------------------------------------- stimulus
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'd0};
  endfunction
  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction
  function automatic logic [31:0] jr(input logic [4:0] rs);
    return {6'd0, rs, 15'd0, 6'd8};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rsv, input logic [31:0] rtv, input logic pred);
    id_valid = 1; id_instr = instr; id_pc = pc; id_sign_ext_imm = imm;
    rf_rs_val = rsv; rf_rt_val = rtv; id_pred_taken = pred;
  endtask

  task automatic tick();
    @(negedge clk);
    id_valid = 0; ex_wr_en = 0; mem_wr_en = 0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rsv, input logic [31:0] rtv, input logic pred);
    drive(instr, pc, imm, rsv, rtv, pred);
    tick();
  endtask

  initial begin
    reset = 1;
    if_pc = 10;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("lit_reset_redirect", {31'd0, redirect}, 0);
    chk("lit_reset_pred", {31'd0, if_pred_taken}, 0);

    // BEQ taken but predicted not-taken; lookup of the same index before the edge.
    drive(itype(6'd4, 5'd1, 5'd2), 10, 5, 7, 7, 0);
    #1 chk("lit_rbw_pred", {31'd0, if_pred_taken}, 0);
    tick();
    chk("lit_beq_redirect", {31'd0, redirect}, 1);
    chk("lit_beq_pc", redirect_pc, 16);
    chk("lit_beq_pred_after", {31'd0, if_pred_taken}, 1);
    tick();
    chk("lit_redirect_one_cycle", {31'd0, redirect}, 0);

    // BNE with rt forwarded from EX: 4 vs 9 -> taken, predicted taken.
    if_pc = 20;
    ex_wr_en = 1; ex_wr_reg = 2; ex_alu_res = 9;
    issue(itype(6'd5, 5'd1, 5'd2), 20, 3, 4, 4, 1);
    chk("lit_bne_no_redirect", {31'd0, redirect}, 0);
    chk("lit_bne_bht4", {31'd0, if_pred_taken}, 1);

    // EX beats MEM on reg 3.
    ex_wr_en = 1; ex_wr_reg = 3; ex_alu_res = 32'hA;
    mem_wr_en = 1; mem_wr_reg = 3; mem_alu_res = 32'hB;
    issue(itype(6'd4, 5'd3, 5'd4), 30, 0, 0, 32'hA, 0);
    chk("lit_fwd_ex_wins", {31'd0, redirect}, 1);
    chk("lit_fwd_ex_pc", redirect_pc, 31);
    // Reg 0 never forwarded.
    ex_wr_en = 1; ex_wr_reg = 0; ex_alu_res = 32'hA;
    mem_wr_en = 1; mem_wr_reg = 0; mem_alu_res = 32'hB;
    issue(itype(6'd4, 5'd0, 5'd4), 32, 0, 5, 5, 0);
    chk("lit_fwd_r0", {31'd0, redirect}, 1);
    // MEM-only forward on rt makes BNE not taken.
    mem_wr_en = 1; mem_wr_reg = 6; mem_alu_res = 7;
    issue(itype(6'd5, 5'd1, 5'd6), 34, 0, 7, 0, 0);
    chk("lit_fwd_mem", {31'd0, redirect}, 0);

    // JAL then matching JR $31.
    issue(jtype(6'd3, 26'h100), 32'h40, 0, 0, 0, 0);
    chk("lit_jal_pc", redirect_pc, 32'h100);
    chk("lit_jal_we", {31'd0, link_we}, 1);
    chk("lit_jal_reg", {27'd0, link_reg}, 31);
    chk("lit_jal_val", link_value, 32'h42);
    issue(jr(5'd31), 32'h50, 0, 32'h42, 0, 0);
    chk("lit_jr_match", {31'd0, redirect}, 0);
    chk("lit_no_uf_yet", {31'd0, ras_underflow}, 0);
    // Plain J with upper PC bits kept.
    issue(jtype(6'd2, 26'h3FF_FFFF), 32'h7000_0005, 0, 0, 0, 0);
    chk("lit_j_pc", redirect_pc, 32'h73FF_FFFF);

    // RAS overflow: five pushes, four pops of the newest, then underflow.
    for (int p = 0; p < 5; p++) issue(jtype(6'd3, 26'h10), p, 0, 0, 0, 0);
    for (int p = 6; p >= 3; p--) begin
      issue(jr(5'd31), 32'h60, 0, p, 0, 0);
      chk("lit_pop_match", {31'd0, redirect}, 0);
    end
    issue(jr(5'd31), 32'h60, 0, 2, 0, 0);
    chk("lit_uf_redirect", {31'd0, redirect}, 1);
    chk("lit_uf_pc", redirect_pc, 2);
    chk("lit_uf_flag", {31'd0, ras_underflow}, 1);
    issue(jr(5'd5), 32'h61, 0, 0, 0, 0);
    chk("lit_jr_zero", {31'd0, redirect}, 0);
    issue(jr(5'd5), 32'h62, 0, 32'h33, 0, 0);
    chk("lit_jr_other", redirect_pc, 32'h33);
    issue(32'h2000_0000, 32'h63, 0, 0, 0, 0);
    chk("lit_nonctrl", {31'd0, redirect}, 0);

    // Saturation at PC 50 (index 2).
    if_pc = 50;
    for (int n = 0; n < 4; n++) issue(itype(6'd4, 5'd1, 5'd2), 50, 1, 3, 3, 1);
    issue(itype(6'd4, 5'd1, 5'd2), 50, 1, 3, 4, 1);
    chk("lit_sat_down_pred", {31'd0, if_pred_taken}, 1);
    chk("lit_sat_down_pc", redirect_pc, 51);
    issue(itype(6'd4, 5'd1, 5'd2), 50, 1, 3, 4, 0);
    chk("lit_counter_1", {31'd0, if_pred_taken}, 0);

    // Reset alongside a JAL clears outputs and discards the stack.
    issue(jtype(6'd3, 26'h200), 32'h97, 0, 0, 0, 0);
    drive(jtype(6'd3, 26'h300), 32'h60, 0, 0, 0, 0);
    reset = 1;
    tick();
    reset = 0;
    chk("lit_rst_redirect", {31'd0, redirect}, 0);
    chk("lit_rst_link_we", {31'd0, link_we}, 0);
    chk("lit_rst_uf", {31'd0, ras_underflow}, 0);
    issue(jr(5'd31), 32'h70, 0, 32'h99, 0, 0);
    chk("lit_rst_ras_empty", {31'd0, redirect}, 1);
    chk("lit_rst_ras_uf", {31'd0, ras_underflow}, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
